ofm_requant_pack: RTL
=====================

# ofm_requant_pack

Output stage directly downstream of the Accumulator. It takes each signed accumulator result on a single-cycle `in_valid` pulse and adds a per-channel bias. It then applies ReLU, a rounded arithmetic right shift and unsigned saturation to `OFM_BIT`. Finally it packs `PACK` consecutive results into one output-feature-map word for the OFM buffer writer.

## Interface
- `IFM_BIT`, 8, input activation width (used only to derive `BIT_ACC`)
- `W_BIT`, 8, weight width (used only to derive `BIT_ACC`)
- `K`, 3, kernel size (used only to derive `BIT_ACC`)
- `IN_CH`, 512, input channels (used only to derive `BIT_ACC`)
- `BIT_ACC`, derived, `IFM_BIT+W_BIT+$clog2(K*K*IN_CH)` = 29 at defaults
- `OFM_BIT`, 8, output activation width
- `PACK`, 4, lanes per output word; ≥1
- `clk`  in  1  single clock; all state on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  `Accumulator` valid this cycle
- `Accumulator`  in  `BIT_ACC`  signed two's-complement accumulator result
- `bias_valid`  in  1  load `bias` into the bias register
- `bias`  in  `BIT_ACC`  signed bias value
- `shift`  in  5  right-shift amount, 0..31
- `flush`  in  1  emit any partially filled word
- `out_valid`  out  1  one-cycle pulse; `ofm_word` and `out_count` are valid
- `ofm_word`  out  `PACK*OFM_BIT`  packed word; lane i occupies bits `[i*OFM_BIT +: OFM_BIT]`
- `out_count`  out  `$clog2(PACK+1)`  number of filled lanes in `ofm_word`

## Operation
- **Bias register.** Written on any edge where `bias_valid`=1. Data sampled on that same edge uses the old bias.
- **Stage 1 (S1).** On `in_valid`:
  - `sum = Accumulator + bias_reg`, sign-extended to `BIT_ACC+2` bits; no overflow is possible.
  - `shift` is captured with the data.
  - A `flush` sampled on the same edge is captured as a marker travelling with the pipeline.
- **Stage 2 (S2).** ReLU: if `sum` < 0, the result is 0.
  - Otherwise `r = (sum + (shift ? 1<<(shift-1) : 0)) >> shift`, i.e. round half up.
- **Stage 3 (S3).** Saturate: `q = min(r, 2^OFM_BIT-1)`.
  - Write `q` into lane `lane_cnt` of the pack register, then increment `lane_cnt`.
- **Word complete.** When `lane_cnt` reaches `PACK`:
  - register `ofm_word`, set `out_count`=`PACK` and pulse `out_valid`;
  - clear the pack register and reset `lane_cnt` to 0.
- **Flush.** Handled when the marker reaches S3, after any data sampled on the same edge.
  - If `lane_cnt`>0: emit the word with unfilled lanes zero and `out_count`=`lane_cnt`, then clear.
  - If `lane_cnt`=0 (including right after a full-word emit): no output.
- **Throughput.** One value per cycle, back-to-back `in_valid` supported. No backpressure; the consumer must accept every `out_valid` pulse.
- **Holding.** `ofm_word` and `out_count` hold their last value between pulses.
- **`shift` changes.** `shift` may change between samples; each value uses the `shift` captured with it.

## Timing
- **Reset.** All outputs and all internal registers are 0 while `rst_n`=0: `out_valid`, `ofm_word`, `out_count`, `bias_reg`, `lane_cnt`, pipeline valids and markers.
- **Reset mid-word.** Discards the partial word and in-flight data; nothing is emitted.
- **Data latency.** `in_valid` high in cycle n, and this value completes a word → `out_valid` high in cycle n+3 only.
- **Flush latency.** `flush` high in cycle n → partial word (if any) appears in cycle n+3.
- **Flush plus data.** If that flush includes the value that completes a word: a single full word is emitted, with `out_count`=`PACK`.
- **Flush without data.** `flush` with `in_valid`=0 still travels the 3-stage pipeline.
- **Pulse width.** `out_valid` is never high two consecutive cycles with `PACK`≥2 unless flush and fill coincide on adjacent values. Each emitted word produces exactly one pulse.
- **Idle inputs.** `Accumulator` and `bias` may be X when their valid is low; outputs must remain non-X.

## Test plan
- **Basic packing.** Reset; bias 0, shift 0; values 10, 20, 30, 40 on consecutive cycles n..n+3 → `out_valid` in cycle n+6 only, `ofm_word`=0x281E140A, `out_count`=4.
- **ReLU, rounding, saturation.** shift=2; values −5, 5, 6, 2000 → lanes 0, 1, 2, 255 → `ofm_word`=0xFF020100.
- **Bias.** `bias_valid` with bias=−100; then values 300, 50, 100, 355 with shift 0 → lanes 200, 0, 0, 255 → `ofm_word`=0xFF0000C8.
- **Bias update timing.** `bias_valid` (bias=7) in the same cycle as value 1 → that lane is 1; the next value 1 gives lane 8.
- **Flush.**
  - Values 1, 2, then `flush` → `ofm_word`=0x00000201, `out_count`=2, three cycles after flush.
  - A second `flush` → no `out_valid`.
  - `flush` together with the 4th value → single word, `out_count`=4.
- **Reset mid-word.** Values 9, 9; assert `rst_n`=0; all outputs 0. After release, values 1, 2, 3, 4 → single word 0x04030201, no stale 9s.

Source files
------------

// File: rtl/ofm_requant_pack.sv
// Output-feature-map requantise and pack stage.
// It adds a per-channel bias to each accumulator result, then applies ReLU, a
// round-half-up right shift and unsigned saturation. The results are packed
// PACK lanes per output word. The pipeline has 3 stages with no backpressure.
module ofm_requant_pack #(
    parameter int IFM_BIT = 8,
    parameter int W_BIT   = 8,
    parameter int K       = 3,
    parameter int IN_CH   = 512,
    parameter int OFM_BIT = 8,
    parameter int PACK    = 4,
    localparam int BIT_ACC = IFM_BIT + W_BIT + $clog2(K * K * IN_CH),
    localparam int CW      = $clog2(PACK + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [BIT_ACC-1:0]      Accumulator,
    input  logic                    bias_valid,
    input  logic [BIT_ACC-1:0]      bias,
    input  logic [4:0]              shift,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [PACK*OFM_BIT-1:0] ofm_word,
    output logic [CW-1:0]           out_count
);

    // Sum width: bias plus accumulator can never overflow BIT_ACC+2 bits.
    localparam int SW = BIT_ACC + 2;
    // Rounding width: must also hold the largest rounding term (1 << 30).
    localparam int RW = (SW > 32) ? SW + 1 : 33;
    localparam logic [RW-1:0] QMAX = {{(RW - OFM_BIT){1'b0}}, {OFM_BIT{1'b1}}};

    logic [BIT_ACC-1:0]      r_bias;
    logic                    r_s1_valid;
    logic                    r_s1_flush;
    logic [SW-1:0]           r_s1_sum;
    logic [4:0]              r_s1_shift;
    logic                    r_s2_valid;
    logic                    r_s2_flush;
    logic [RW-1:0]           r_s2_r;
    logic [PACK*OFM_BIT-1:0] r_pack;
    logic [CW-1:0]           r_lane_cnt;
    logic                    r_out_valid;
    logic [PACK*OFM_BIT-1:0] r_ofm_word;
    logic [CW-1:0]           r_out_count;

    logic [SW-1:0]           w_sum;
    logic [RW-1:0]           w_ext;
    logic [RW-1:0]           w_rnd;
    logic [RW-1:0]           w_relu;
    logic [OFM_BIT-1:0]      w_q;
    logic [PACK*OFM_BIT-1:0] w_pack;
    logic [CW-1:0]           w_cnt;
    logic                    w_emit;

    assign out_valid = r_out_valid;
    assign ofm_word  = r_ofm_word;
    assign out_count = r_out_count;

    // Bias register; a sample taken on the same edge still sees the old bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias <= '0;
        end else if (bias_valid) begin
            r_bias <= bias;
        end
    end

    assign w_sum = {{2{Accumulator[BIT_ACC-1]}}, Accumulator}
                 + {{2{r_bias[BIT_ACC-1]}}, r_bias};

    // S1: biased sum, captured shift and flush marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_flush <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_shift <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_flush <= flush;
            if (in_valid) begin
                r_s1_sum   <= w_sum;
                r_s1_shift <= shift;
            end
        end
    end

    // S2 combinational: ReLU plus round-half-up arithmetic shift.
    always_comb begin
        w_ext  = {{(RW - SW){1'b0}}, r_s1_sum};
        w_rnd  = '0;
        if (r_s1_shift != 5'd0) begin
            w_rnd = RW'(1) << (r_s1_shift - 5'd1);
        end
        w_relu = (w_ext + w_rnd) >> r_s1_shift;
        if (r_s1_sum[SW-1]) begin
            w_relu = '0;
        end
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_flush <= 1'b0;
            r_s2_r     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_flush <= r_s1_flush;
            if (r_s1_valid) begin
                r_s2_r <= w_relu;
            end
        end
    end

    // S3 combinational: saturate, insert into the current lane, decide emit.
    // The data lane is inserted before the flush marker is considered.
    always_comb begin
        w_q    = (r_s2_r > QMAX) ? {OFM_BIT{1'b1}} : r_s2_r[OFM_BIT-1:0];
        w_pack = r_pack;
        w_cnt  = r_lane_cnt;
        if (r_s2_valid) begin
            for (int i = 0; i < PACK; i++) begin
                if (CW'(i) == r_lane_cnt) begin
                    w_pack[i*OFM_BIT +: OFM_BIT] = w_q;
                end
            end
            w_cnt = r_lane_cnt + CW'(1);
        end
        w_emit = (r_s2_valid && (w_cnt == CW'(PACK))) || (r_s2_flush && (w_cnt != '0));
    end

    // S3 register: pack accumulation and output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack      <= '0;
            r_lane_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_ofm_word  <= '0;
            r_out_count <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_ofm_word  <= w_pack;
                r_out_count <= w_cnt;
                r_pack      <= '0;
                r_lane_cnt  <= '0;
            end else begin
                r_pack     <= w_pack;
                r_lane_cnt <= w_cnt;
            end
        end
    end

endmodule
